// File: rtl/pe_scratchpad.sv
// Per-PE scratchpad: valid/ready request channel, registered read response held
// under backpressure, and a hardware clear sweep after reset and on request.
module pe_scratchpad #(
  parameter int num_bits  = 8,
  parameter int depth     = 64,
  parameter int addr_bits = $clog2(depth)
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_clear,
  input  logic                 w_req_valid,
  output logic                 r_req_ready,
  input  logic                 w_req_write,
  input  logic [addr_bits-1:0] w_req_addr,
  input  logic [num_bits-1:0]  w_req_data,
  output logic                 r_rsp_valid,
  input  logic                 w_rsp_ready,
  output logic [num_bits-1:0]  r_rsp_data,
  output logic                 r_rsp_err,
  output logic                 r_busy
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t               state, state_nxt;
  logic [addr_bits-1:0] cnt, cnt_nxt;
  logic [num_bits-1:0]  mem [depth];
  logic                 accept, in_range, last;

  // depth need not be a power of two, so the top of the address space can be unmapped
  assign in_range    = 32'(w_req_addr) < depth;
  assign last        = (cnt == addr_bits'(depth - 1));
  assign r_busy      = (state == CLEAR);
  assign r_req_ready = (state == IDLE) && !w_clear && (!r_rsp_valid || w_rsp_ready);
  assign accept      = w_req_valid && r_req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = last ? '0 : cnt + 1'b1;
        if (last) state_nxt = IDLE;
      end
      IDLE: if (w_clear) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Contents are not reset; the sweep zeroes them.
  always_ff @(posedge w_clk) begin
    if (state == CLEAR)
      mem[cnt] <= '0;
    else if (accept && w_req_write && in_range)
      mem[w_req_addr] <= w_req_data;
  end

  // A pending response survives a sweep start; only a handshake or reset drops it.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (accept && !w_req_write) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= !in_range;
      r_rsp_data  <= in_range ? mem[w_req_addr] : '0;
    end else if (w_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule
